// File: rtl/dps_bridge_pkg.sv
// Shared types, address map constants and decode for the DPS request bridge.
package dps_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    ERR_RESP = 2'd2
  } bridgeState_t;

  localparam logic [31:0] DPS_UTIM64_LAST = 32'h0000_0074;
  localparam logic [31:0] DPS_SCI_ADDR0   = 32'h0000_0100;
  localparam logic [31:0] DPS_SCI_ADDR1   = 32'h0000_0108;

  // Queue entry layout: {rw, addr[31:0], data[31:0]}
  localparam int ENTRY_W = 65;

  // True when the byte address hits a decoded DPS register.
  function automatic logic mapped(input logic [31:0] addr);
    return ((addr <= DPS_UTIM64_LAST) && (addr[1:0] == 2'b00)) ||
           (addr == DPS_SCI_ADDR0) ||
           (addr == DPS_SCI_ADDR1);
  endfunction

endpackage

// File: rtl/dps_bridge_fifo.sv
// In-order request queue; head is read combinationally from the read pointer.
module dps_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             iCLOCK,
  input  logic             iRESET_SYNC,
  input  logic             iPUSH,
  input  logic [WIDTH-1:0] iPUSH_DATA,
  input  logic             iPOP,
  output logic             oFULL,
  output logic             oEMPTY,
  output logic [WIDTH-1:0] oHEAD
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign oFULL  = (count == CW'(DEPTH));
  assign oEMPTY = (count == '0);
  assign doPush = iPUSH && !oFULL;
  assign doPop  = iPOP && !oEMPTY;
  assign oHEAD  = mem[rdPtr];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge iCLOCK) begin
    if (doPush) mem[wrPtr] <= iPUSH_DATA;
  end

endmodule

// File: rtl/dps_req_bridge.sv
// CPU-to-DPS request bridge: queues accesses, issues mapped ones with REQ/BUSY,
// keeps one read outstanding and completes unmapped/timed-out accesses locally.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | inspect queue head; issue mapped, retire unmapped locally
// RD_WAIT  | one read outstanding at the DPS, waiting for iDPS_VALID
// ERR_RESP | one-cycle error response (unmapped read or read timeout)
module dps_req_bridge
  import dps_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DPS_TIMEOUT = 255
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic        iREQ_RW,
  input  logic [31:0] iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  output logic        oRESP_VALID,
  output logic [31:0] oRESP_DATA,
  output logic        oRESP_ERROR,
  output logic        oWRITE_DROP,
  output logic        oDPS_REQ,
  input  logic        iDPS_BUSY,
  output logic        oDPS_RW,
  output logic [31:0] oDPS_ADDR,
  output logic [31:0] oDPS_DATA,
  input  logic        iDPS_VALID,
  input  logic [31:0] iDPS_DATA
);

  localparam int CNT_W = $clog2(DPS_TIMEOUT + 1);
  // The counter starts at 0 in the first RD_WAIT cycle, so it reaches the
  // timeout on the update made in the cycle where it holds DPS_TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DPS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DPS_TIMEOUT);

  bridgeState_t       state;
  bridgeState_t       stateNext;
  logic [CNT_W-1:0]   cnt;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] headEntry;
  logic               headRw;
  logic [31:0]        headAddr;
  logic [31:0]        headData;
  logic               headMapped;
  logic               push;
  logic               pop;
  logic               dpsReq;
  logic               cntClear;
  logic               cntInc;
  logic               respLoad;
  logic               dropNext;
  logic               respValidQ;
  logic [31:0]        respDataQ;
  logic               dropQ;

  assign push = iREQ_VALID && !fifoFull;

  dps_bridge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (push),
    .iPUSH_DATA  ({iREQ_RW, iREQ_ADDR, iREQ_DATA}),
    .iPOP        (pop),
    .oFULL       (fifoFull),
    .oEMPTY      (fifoEmpty),
    .oHEAD       (headEntry)
  );

  assign headRw     = headEntry[64];
  assign headAddr   = headEntry[63:32];
  assign headData   = headEntry[31:0];
  assign headMapped = mapped(headAddr);

  // Next-state and control decode.
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    dpsReq    = 1'b0;
    cntClear  = 1'b0;
    cntInc    = 1'b0;
    respLoad  = 1'b0;
    dropNext  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          if (headMapped) begin
            dpsReq = 1'b1;
            if (!iDPS_BUSY) begin
              pop = 1'b1;
              if (!headRw) begin
                stateNext = RD_WAIT;
                cntClear  = 1'b1;
              end
            end
          end else begin
            pop = 1'b1;
            if (headRw) dropNext  = 1'b1;
            else        stateNext = ERR_RESP;
          end
        end
      end
      RD_WAIT: begin
        if (iDPS_VALID) begin
          respLoad  = 1'b1;
          stateNext = IDLE;
        end else if (cnt == CNT_LAST) begin
          stateNext = ERR_RESP;
        end else begin
          cntInc = 1'b1;
        end
      end
      ERR_RESP: stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) state <= IDLE;
    else             state <= stateNext;
  end

  // Timeout counter, read-data capture and one-cycle response/drop pulses.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      cnt        <= '0;
      respValidQ <= 1'b0;
      respDataQ  <= '0;
      dropQ      <= 1'b0;
    end else begin
      if (cntClear)                     cnt <= '0;
      else if (cntInc && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      respValidQ <= respLoad;
      if (respLoad) respDataQ <= iDPS_DATA;
      dropQ <= dropNext;
    end
  end

  assign oREQ_BUSY   = fifoFull;
  assign oDPS_REQ    = dpsReq;
  assign oDPS_RW     = !fifoEmpty && headRw;
  assign oDPS_ADDR   = fifoEmpty ? 32'h0 : headAddr;
  assign oDPS_DATA   = fifoEmpty ? 32'h0 : headData;
  assign oRESP_VALID = respValidQ || (state == ERR_RESP);
  assign oRESP_ERROR = (state == ERR_RESP);
  assign oRESP_DATA  = respValidQ ? respDataQ : 32'h0;
  assign oWRITE_DROP = dropQ;

endmodule

// File: tb/tb_dps_req_bridge.sv
// Directed bench for dps_req_bridge (FIFO_DEPTH=4, DPS_TIMEOUT=8).
module tb_dps_req_bridge;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iREQ_VALID;
  logic        iREQ_RW;
  logic [31:0] iREQ_ADDR;
  logic [31:0] iREQ_DATA;
  logic        iDPS_BUSY;
  logic        iDPS_VALID;
  logic [31:0] iDPS_DATA;
  logic        oREQ_BUSY;
  logic        oRESP_VALID;
  logic [31:0] oRESP_DATA;
  logic        oRESP_ERROR;
  logic        oWRITE_DROP;
  logic        oDPS_REQ;
  logic        oDPS_RW;
  logic [31:0] oDPS_ADDR;
  logic [31:0] oDPS_DATA;

  int checks = 0;
  int errors = 0;

  dps_req_bridge #(
    .FIFO_DEPTH  (4),
    .DPS_TIMEOUT (8)
  ) dut (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iREQ_VALID  (iREQ_VALID),
    .oREQ_BUSY   (oREQ_BUSY),
    .iREQ_RW     (iREQ_RW),
    .iREQ_ADDR   (iREQ_ADDR),
    .iREQ_DATA   (iREQ_DATA),
    .oRESP_VALID (oRESP_VALID),
    .oRESP_DATA  (oRESP_DATA),
    .oRESP_ERROR (oRESP_ERROR),
    .oWRITE_DROP (oWRITE_DROP),
    .oDPS_REQ    (oDPS_REQ),
    .iDPS_BUSY   (iDPS_BUSY),
    .oDPS_RW     (oDPS_RW),
    .oDPS_ADDR   (oDPS_ADDR),
    .oDPS_DATA   (oDPS_DATA),
    .iDPS_VALID  (iDPS_VALID),
    .iDPS_DATA   (iDPS_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkResp(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, "_rvalid"}, {31'b0, oRESP_VALID}, {31'b0, v});
    chk({tag, "_rerror"}, {31'b0, oRESP_ERROR}, {31'b0, e});
    chk({tag, "_rdata"}, oRESP_DATA, d);
  endtask

  task automatic chkDps(input string tag, input logic rq, input logic rw,
                        input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_dreq"}, {31'b0, oDPS_REQ}, {31'b0, rq});
    chk({tag, "_drw"}, {31'b0, oDPS_RW}, {31'b0, rw});
    chk({tag, "_daddr"}, oDPS_ADDR, a);
    chk({tag, "_ddata"}, oDPS_DATA, d);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_busy"}, {31'b0, oREQ_BUSY}, 32'h0);
    chk({tag, "_drop"}, {31'b0, oWRITE_DROP}, 32'h0);
    chkResp(tag, 1'b0, 1'b0, 32'h0);
    chkDps(tag, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge iCLOCK);
    #2;
  endtask

  task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d);
    iREQ_VALID = 1'b1;
    iREQ_RW    = rw;
    iREQ_ADDR  = a;
    iREQ_DATA  = d;
  endtask

  task automatic noReq();
    iREQ_VALID = 1'b0;
    iREQ_RW    = 1'b0;
    iREQ_ADDR  = 32'h0;
    iREQ_DATA  = 32'h0;
  endtask

  initial begin
    iRESET_SYNC = 1'b1;
    iDPS_BUSY   = 1'b0;
    iDPS_VALID  = 1'b0;
    iDPS_DATA   = 32'h0;
    noReq();

    // Reset state
    step(); step(); #1;
    chkAllZero("reset");

    // Mapped read 0x08, data three cycles after accept
    step(); iRESET_SYNC = 1'b0; req(1'b0, 32'h08, 32'h0); #1;
    chk("t1_noreq_empty", {31'b0, oDPS_REQ}, 32'h0);
    step(); noReq(); #1;
    chkDps("t1_issue", 1'b1, 1'b0, 32'h08, 32'h0);
    step(); #1;
    chk("t1_single_req", {31'b0, oDPS_REQ}, 32'h0);
    chkResp("t1_wait0", 1'b0, 1'b0, 32'h0);
    step(); #1;
    chkResp("t1_wait1", 1'b0, 1'b0, 32'h0);
    step(); iDPS_VALID = 1'b1; iDPS_DATA = 32'hCAFE0001; #1;
    chkResp("t1_wait2", 1'b0, 1'b0, 32'h0);
    step(); iDPS_VALID = 1'b0; iDPS_DATA = 32'h0; #1;
    chkResp("t1_resp", 1'b1, 1'b0, 32'hCAFE0001);
    step(); #1;
    chkResp("t1_after", 1'b0, 1'b0, 32'h0);
    chk("t1_after_dreq", {31'b0, oDPS_REQ}, 32'h0);

    // Two writes held off by DPS busy for 5 cycles
    step(); iDPS_BUSY = 1'b1; req(1'b1, 32'h100, 32'h41); #1;
    step(); req(1'b1, 32'h108, 32'h42); #1;
    chkDps("t2_busy1", 1'b1, 1'b1, 32'h100, 32'h41);
    step(); noReq(); #1;
    chkDps("t2_busy2", 1'b1, 1'b1, 32'h100, 32'h41);
    for (int k = 3; k <= 4; k++) begin
      step(); #1;
      chkDps("t2_busyN", 1'b1, 1'b1, 32'h100, 32'h41);
    end
    step(); iDPS_BUSY = 1'b0; #1;
    chkDps("t2_acc0", 1'b1, 1'b1, 32'h100, 32'h41);
    step(); #1;
    chkDps("t2_acc1", 1'b1, 1'b1, 32'h108, 32'h42);
    chkResp("t2_noresp", 1'b0, 1'b0, 32'h0);
    step(); #1;
    chk("t2_done_dreq", {31'b0, oDPS_REQ}, 32'h0);
    chkResp("t2_done", 1'b0, 1'b0, 32'h0);

    // Unmapped read 0x104 then unmapped write 0x200
    step(); req(1'b0, 32'h104, 32'h0); #1;
    step(); req(1'b1, 32'h200, 32'h99); #1;
    chk("t3_noreq_rd", {31'b0, oDPS_REQ}, 32'h0);
    chkResp("t3_pre", 1'b0, 1'b0, 32'h0);
    step(); noReq(); #1;
    chkResp("t3_err", 1'b1, 1'b1, 32'h0);
    chk("t3_err_dreq", {31'b0, oDPS_REQ}, 32'h0);
    step(); #1;
    chk("t3_noreq_wr", {31'b0, oDPS_REQ}, 32'h0);
    chk("t3_drop_pre", {31'b0, oWRITE_DROP}, 32'h0);
    chkResp("t3_idle", 1'b0, 1'b0, 32'h0);
    step(); #1;
    chk("t3_drop", {31'b0, oWRITE_DROP}, 32'h1);
    chk("t3_drop_dreq", {31'b0, oDPS_REQ}, 32'h0);
    step(); #1;
    chk("t3_drop_end", {31'b0, oWRITE_DROP}, 32'h0);

    // Address map edges: 0x74 mapped, 0x78 and misaligned 0x06 unmapped
    step(); req(1'b1, 32'h74, 32'hA); #1;
    step(); req(1'b1, 32'h78, 32'hB); #1;
    chkDps("map_74", 1'b1, 1'b1, 32'h74, 32'hA);
    step(); req(1'b1, 32'h06, 32'hC); #1;
    chk("map_78_req", {31'b0, oDPS_REQ}, 32'h0);
    chk("map_74_nodrop", {31'b0, oWRITE_DROP}, 32'h0);
    step(); noReq(); #1;
    chk("map_06_req", {31'b0, oDPS_REQ}, 32'h0);
    chk("map_78_drop", {31'b0, oWRITE_DROP}, 32'h1);
    step(); #1;
    chk("map_06_drop", {31'b0, oWRITE_DROP}, 32'h1);
    step(); #1;
    chk("map_drop_end", {31'b0, oWRITE_DROP}, 32'h0);

    // Read timeout, then a late iDPS_VALID is ignored
    step(); req(1'b0, 32'h10, 32'h0); #1;
    step(); noReq(); #1;
    chkDps("t4_issue", 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 2; k <= 9; k++) begin
      step(); #1;
      chkResp("t4_wait", 1'b0, 1'b0, 32'h0);
    end
    step(); #1;
    chkResp("t4_timeout", 1'b1, 1'b1, 32'h0);
    step(); iDPS_VALID = 1'b1; iDPS_DATA = 32'hDEAD0000; #1;
    chkResp("t4_late0", 1'b0, 1'b0, 32'h0);
    step(); iDPS_VALID = 1'b0; iDPS_DATA = 32'h0; #1;
    chkResp("t4_late1", 1'b0, 1'b0, 32'h0);
    chk("t4_late_dreq", {31'b0, oDPS_REQ}, 32'h0);

    // iDPS_VALID on the timeout cycle wins
    step(); req(1'b0, 32'h40, 32'h0); #1;
    step(); noReq(); #1;
    chkDps("t7_issue", 1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      step(); #1;
      chkResp("t7_wait", 1'b0, 1'b0, 32'h0);
    end
    step(); iDPS_VALID = 1'b1; iDPS_DATA = 32'h77; #1;
    chkResp("t7_edge", 1'b0, 1'b0, 32'h0);
    step(); iDPS_VALID = 1'b0; iDPS_DATA = 32'h0; #1;
    chkResp("t7_resp", 1'b1, 1'b0, 32'h77);
    step(); #1;
    chkResp("t7_after", 1'b0, 1'b0, 32'h0);

    // Backlog of FIFO_DEPTH+1 writes behind a pending read
    step(); req(1'b0, 32'h20, 32'h0); #1;
    step(); req(1'b1, 32'h00, 32'h1); #1;
    chkDps("t5_rd", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t5_busy1", {31'b0, oREQ_BUSY}, 32'h0);
    step(); req(1'b1, 32'h04, 32'h2); #1;
    chk("t5_busy2", {31'b0, oREQ_BUSY}, 32'h0);
    chk("t5_hold_dreq", {31'b0, oDPS_REQ}, 32'h0);
    step(); req(1'b1, 32'h0C, 32'h3); #1;
    chk("t5_busy3", {31'b0, oREQ_BUSY}, 32'h0);
    step(); req(1'b1, 32'h10, 32'h4); #1;
    chk("t5_busy4", {31'b0, oREQ_BUSY}, 32'h0);
    step(); req(1'b1, 32'h14, 32'h5); #1;
    chk("t5_full", {31'b0, oREQ_BUSY}, 32'h1);
    chk("t5_full_dreq", {31'b0, oDPS_REQ}, 32'h0);
    step(); iDPS_VALID = 1'b1; iDPS_DATA = 32'h55; #1;
    chk("t5_full2", {31'b0, oREQ_BUSY}, 32'h1);
    step(); iDPS_VALID = 1'b0; iDPS_DATA = 32'h0; #1;
    chkResp("t5_resp", 1'b1, 1'b0, 32'h55);
    chk("t5_full3", {31'b0, oREQ_BUSY}, 32'h1);
    chkDps("t5_q1", 1'b1, 1'b1, 32'h00, 32'h1);
    step(); #1;
    chk("t5_room", {31'b0, oREQ_BUSY}, 32'h0);
    chkDps("t5_q2", 1'b1, 1'b1, 32'h04, 32'h2);
    step(); noReq(); #1;
    chkDps("t5_q3", 1'b1, 1'b1, 32'h0C, 32'h3);
    step(); #1;
    chkDps("t5_q4", 1'b1, 1'b1, 32'h10, 32'h4);
    step(); #1;
    chkDps("t5_q5", 1'b1, 1'b1, 32'h14, 32'h5);
    step(); #1;
    chkDps("t5_empty", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_empty_busy", {31'b0, oREQ_BUSY}, 32'h0);

    // Reset during RD_WAIT, then a stray iDPS_VALID, then a clean read
    step(); req(1'b0, 32'h30, 32'h0); #1;
    step(); noReq(); #1;
    chkDps("t6_issue", 1'b1, 1'b0, 32'h30, 32'h0);
    step(); iRESET_SYNC = 1'b1; #1;
    chk("t6_wait_dreq", {31'b0, oDPS_REQ}, 32'h0);
    step(); iRESET_SYNC = 1'b0; iDPS_VALID = 1'b1; iDPS_DATA = 32'h0BAD; #1;
    chkAllZero("t6_reset");
    step(); iDPS_VALID = 1'b0; iDPS_DATA = 32'h0; req(1'b0, 32'h34, 32'h0); #1;
    chkAllZero("t6_stray");
    step(); noReq(); #1;
    chkDps("t6_issue2", 1'b1, 1'b0, 32'h34, 32'h0);
    step(); iDPS_VALID = 1'b1; iDPS_DATA = 32'h12345678; #1;
    chkResp("t6_wait", 1'b0, 1'b0, 32'h0);
    step(); iDPS_VALID = 1'b0; iDPS_DATA = 32'h0; #1;
    chkResp("t6_resp", 1'b1, 1'b0, 32'h12345678);
    step(); #1;
    chkResp("t6_after", 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dps_req_bridge.md
Name: dps_req_bridge

Overview:
- Upstream feeder of the default peripheral system (DPS); sits between the CPU load/store path and the DPS request port.
- Buffers CPU accesses in a small in-order FIFO and decodes each against the DPS address map.
- Issues mapped accesses with the DPS REQ/BUSY handshake, allows one outstanding read, and returns read data or an error response to the CPU.
- Unmapped accesses and DPS read timeouts are completed locally and never reach the DPS.

Parameters:
- FIFO_DEPTH, 4, request queue entries; power of two, 2..16.
- DPS_TIMEOUT, 255, cycles to wait for iDPS_VALID after a read is accepted before answering with an error.

Ports:
- iCLOCK  in  1  system clock
- iRESET_SYNC  in  1  reset, synchronous, active-high
- iREQ_VALID  in  1  CPU access request
- oREQ_BUSY  out  1  queue full; a request is accepted only when iREQ_VALID=1 and oREQ_BUSY=0
- iREQ_RW  in  1  1 = write
- iREQ_ADDR  in  32  DPS byte address
- iREQ_DATA  in  32  write data
- oRESP_VALID  out  1  one-cycle read-response pulse
- oRESP_DATA  out  32  read data; 0 when oRESP_ERROR=1
- oRESP_ERROR  out  1  read was unmapped or timed out; qualified by oRESP_VALID
- oWRITE_DROP  out  1  one-cycle pulse: an unmapped write was discarded
- oDPS_REQ  out  1  request to DPS
- iDPS_BUSY  in  1  DPS busy; the DPS accepts a request when oDPS_REQ=1 and iDPS_BUSY=0
- oDPS_RW  out  1  to DPS
- oDPS_ADDR  out  32  to DPS
- oDPS_DATA  out  32  to DPS
- iDPS_VALID  in  1  DPS read data valid
- iDPS_DATA  in  32  DPS read data

Behaviour:
- Clock and reset: single clock iCLOCK; iRESET_SYNC is synchronous and active-high.
- Reset: FIFO emptied, state IDLE, timeout counter cleared. All outputs read 0: oREQ_BUSY, oRESP_*, oWRITE_DROP, oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA.
- Reset mid-operation: abandons any in-flight read without a response. A later iDPS_VALID is ignored.
- FIFO:
  - Entry = {rw, addr[31:0], data[31:0]}.
  - A push written in cycle N is visible at the head in cycle N+1.
  - oREQ_BUSY = full.
  - Push and pop in the same cycle are both honoured.
- Address map (mapped = true):
  - addr <= 32'h74 with addr[1:0]=0;
  - addr == 32'h100;
  - addr == 32'h108.
  - Everything else is unmapped, including misaligned addresses.
- Outputs toward the DPS:
  - oDPS_RW/ADDR/DATA show the FIFO head combinationally.
  - oDPS_REQ = (state==IDLE) && !empty && mapped(head).
  - Accept = oDPS_REQ && !iDPS_BUSY; the head is popped on the accept cycle.
- FSM states:
  - IDLE:
    - head mapped write, accepted -> pop, stay IDLE; writes give no CPU response.
    - head mapped read, accepted -> pop, go to RD_WAIT, clear the timeout counter.
    - head unmapped read -> pop without oDPS_REQ, go to ERR_RESP.
    - head unmapped write -> pop without oDPS_REQ, pulse oWRITE_DROP the next cycle, stay IDLE.
    - empty, or iDPS_BUSY=1 -> hold.
  - RD_WAIT (no further issue, so exactly one read is outstanding):
    - iDPS_VALID=1 -> register iDPS_DATA, pulse oRESP_VALID with ERROR=0 the next cycle, go to IDLE.
    - counter reaches DPS_TIMEOUT -> go to ERR_RESP.
    - otherwise increment the counter.
  - ERR_RESP: oRESP_VALID=1, oRESP_ERROR=1, oRESP_DATA=0 for one cycle, then IDLE.
- Timing:
  - Read latency: response appears exactly 1 cycle after iDPS_VALID.
  - Minimum time from iREQ_VALID to oDPS_REQ is 1 cycle.
- Boundary conditions:
  - iDPS_VALID outside RD_WAIT (stray, or after a timeout) is ignored.
  - iDPS_VALID arriving in the same cycle the counter reaches DPS_TIMEOUT is treated as valid data and wins over the timeout.
  - Timeout counter width = clog2(DPS_TIMEOUT+1); it saturates and never wraps.
  - Ordering: responses are returned in request order; writes queued behind a read wait for that read to complete.

Decomposition:
- Package dps_bridge_pkg holds:
  - state encodings IDLE/RD_WAIT/ERR_RESP;
  - address constants DPS_UTIM64_LAST=32'h74, DPS_SCI_ADDR0=32'h100, DPS_SCI_ADDR1=32'h108;
  - FIFO entry width 65;
  - the mapped() decode function.
- Sub-module dps_bridge_fifo: parameterised synchronous FIFO with push/pop/full/empty/head outputs; clear on iRESET_SYNC.

Test Plan:
- Read 0x08 with iDPS_BUSY=0; DPS returns iDPS_VALID with 32'hCAFE0001 three cycles after accept -> exactly one oDPS_REQ (RW=0, ADDR=0x08); oRESP_VALID one cycle after iDPS_VALID with DATA=32'hCAFE0001, ERROR=0.
- Writes to 0x100 (data 0x41) then 0x108 (data 0x42) with iDPS_BUSY=1 for 5 cycles -> no accept while busy; after BUSY falls, two accepts in order with data 0x41 then 0x42; no oRESP_VALID.
- Read 0x104, then write 0x200 -> ERR_RESP response (VALID=1, ERROR=1, DATA=0) two cycles after push with no oDPS_REQ; then one oWRITE_DROP pulse, again with no oDPS_REQ.
- Read 0x10 with the DPS never answering, DPS_TIMEOUT=8 -> error response 9 cycles after accept; an iDPS_VALID injected afterwards produces no response.
- Push FIFO_DEPTH+1 requests back-to-back while a read is pending -> oREQ_BUSY=1 after FIFO_DEPTH pushes; the extra request is held off; the queue drains in order.
- Assert iRESET_SYNC for 1 cycle during RD_WAIT, then send iDPS_VALID -> all outputs 0, FIFO empty, no oRESP_VALID; the next read completes normally.
